// File: rtl/lsu_mem_resp_pkg.sv
// lsu_mem_resp_pkg: access codes, bus widths and FSM state encoding shared by the LSU files.
package lsu_mem_resp_pkg;
  localparam int BUS_DW = 32;
  localparam int BUS_BE_W = BUS_DW / 8;
  localparam logic [2:0] LOAD_LB = 3'b000;
  localparam logic [2:0] LOAD_LH = 3'b001;
  localparam logic [2:0] LOAD_LW = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;
  localparam logic [2:0] STORE_SB = 3'b000;
  localparam logic [2:0] STORE_SH = 3'b001;
  localparam logic [2:0] STORE_SW = 3'b010;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_e;
endpackage

// File: rtl/lsu_mem_resp_align.sv
// lsu_align: combinational store lane shift / byte enables / misalign check and load extract / extend.
module lsu_align
  import lsu_mem_resp_pkg::*;
(
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [2:0]        load_code,
  input  logic [2:0]        store_code,
  input  logic [BUS_DW-1:0] wdata,
  output logic [BUS_BE_W-1:0] be,
  output logic [BUS_DW-1:0] lane_wdata,
  output logic              misalign,
  input  logic [1:0]        raddr,
  input  logic [2:0]        rcode,
  input  logic [BUS_DW-1:0] rdata,
  output logic [BUS_DW-1:0] rdata_ext
);
  logic is_byte, is_half;
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  always_comb begin
    is_byte = we ? store_code == STORE_SB : (load_code == LOAD_LB || load_code == LOAD_LBU);
    is_half = we ? store_code == STORE_SH : (load_code == LOAD_LH || load_code == LOAD_LHU);
    misalign = is_half ? addr[0] : (!is_byte && addr != 2'b00);
    be = !we ? 4'b1111 : is_byte ? 4'b0001 << addr : is_half ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    lane_wdata = is_byte ? {4{wdata[7:0]}} : is_half ? {2{wdata[15:0]}} : wdata;
    rbyte = rdata[{raddr, 3'b000} +: 8];
    rhalf = raddr[1] ? rdata[31:16] : rdata[15:0];
    rdata_ext = rcode == LOAD_LB  ? {{24{rbyte[7]}}, rbyte}
              : rcode == LOAD_LBU ? {24'b0, rbyte}
              : rcode == LOAD_LH  ? {{16{rhalf[15]}}, rhalf}
              : rcode == LOAD_LHU ? {16'b0, rhalf}
              : rdata;
  end
endmodule

// File: rtl/lsu_mem_resp.sv
// lsu_mem_resp: single-outstanding load/store unit bridging EX to the req/gnt/rvalid data bus.
// Optional response timeout (reported on misalign_o) enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_resp
  import lsu_mem_resp_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_req_i,
  input  logic              ex_we_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic [2:0]        load_code_i,
  input  logic [2:0]        store_code_i,
  input  logic [4:0]        ex_rd_addr_i,
  output logic              hold_req_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              wb_valid_o,
  output logic [4:0]        wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              misalign_o
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic we_q, ret_q, misalign_q, wb_valid_q;
  logic [2:0] code_q;
  logic [4:0] rd_q;
  logic [3:0] be_q, be;
  logic [DATA_W-1:0] wdata_q, lane_wdata, rdata_ext, wb_data_q;
  logic misalign, accept, reject, done, timeout;

  lsu_align u_align (
    .we(ex_we_i), .addr(ex_addr_i[1:0]), .load_code(load_code_i), .store_code(store_code_i),
    .wdata(ex_wdata_i), .be(be), .lane_wdata(lane_wdata), .misalign(misalign),
    .raddr(addr_q[1:0]), .rcode(code_q), .rdata(bus_rdata_i), .rdata_ext(rdata_ext)
  );

`ifdef LSU_TIMEOUT_EN
  logic [7:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= state_q == RESP ? cnt_q + 8'd1 : 8'd0;
  assign timeout = state_q == RESP && !bus_rvalid_i && cnt_q == 8'(TIMEOUT_CYC - 1);
`else
  assign timeout = 1'b0 && TIMEOUT_CYC < 0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;

  // ret_q blocks acceptance in the cycle the FSM lands back in IDLE
  always_comb begin
    accept = state_q == IDLE && ex_req_i && !ret_q && !misalign;
    reject = state_q == IDLE && ex_req_i && !ret_q && misalign;
    done = bus_rvalid_i && (state_q == RESP || (state_q == REQ && bus_gnt_i));
    state_d = state_q == IDLE ? (accept ? REQ : IDLE)
            : state_q == REQ ? (bus_gnt_i ? (bus_rvalid_i ? IDLE : RESP) : REQ)
            : (bus_rvalid_i || timeout) ? IDLE : RESP;
  end

  always_comb begin
    hold_req_o = state_q == IDLE ? accept : 1'b1;
    bus_req_o = state_q == REQ;
    bus_we_o = bus_req_o && we_q;
    bus_addr_o = bus_req_o ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    bus_be_o = bus_req_o ? be_q : '0;
    bus_wdata_o = bus_we_o ? wdata_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q <= '0;
      we_q <= 1'b0;
      code_q <= '0;
      rd_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      ret_q <= 1'b0;
      misalign_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q <= '0;
    end else begin
      ret_q <= state_q != IDLE && state_d == IDLE;
      misalign_q <= reject || timeout;
      wb_valid_q <= done && !we_q;
      if (done && !we_q) wb_data_q <= rdata_ext;
      if (accept) begin
        addr_q <= ex_addr_i;
        we_q <= ex_we_i;
        code_q <= ex_we_i ? store_code_i : load_code_i;
        rd_q <= ex_rd_addr_i;
        be_q <= be;
        wdata_q <= lane_wdata;
      end
    end

  assign wb_valid_o = wb_valid_q;
  assign wb_addr_o = rd_q;
  assign wb_data_o = wb_data_q;
  assign misalign_o = misalign_q;
endmodule
